// File: rtl/mips_pkg.sv
// Shared MIPS core constants: datapath width, register-file geometry, hardwired zero register.
package mips_pkg;

    localparam int unsigned DW_C     = 32;
    localparam int unsigned AW_C     = 5;
    localparam int unsigned NREG_C   = 32;
    localparam int unsigned REG_ZERO = 0;

endpackage : mips_pkg

// File: rtl/reg_file_wb_wr_decoder.sv
// Enable-gated AW -> NREG one-hot decoder; output bit 0 is never asserted (register 0 is hardwired).
module wr_decoder
    import mips_pkg::*;
#(
    parameter int unsigned AW   = AW_C,
    parameter int unsigned NREG = NREG_C
) (
    input  logic            en_i,
    input  logic [AW-1:0]   addr_i,
    output logic [NREG-1:0] onehot_o
);

    // One-hot decode of addr_i when enabled, with the zero-register select forced low.
    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[addr_i] = 1'b1;
        end
        onehot_o[REG_ZERO] = 1'b0;
    end

endmodule : wr_decoder

// File: rtl/reg_file_wb.sv
// MIPS register file with write-back decode, two combinational read ports, optional
// same-cycle write-to-read forwarding, and a per-register load-busy scoreboard.
module reg_file_wb
    import mips_pkg::*;
#(
    parameter int unsigned DW     = DW_C,
    parameter int unsigned NREG   = NREG_C,
    parameter int unsigned AW     = AW_C,
    parameter int unsigned BYPASS = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          ld_issue,
    input  logic [AW-1:0] ld_dst,
    output logic          busy1,
    output logic          busy2,
    output logic          stall
);

    localparam bit BYP_EN = (BYPASS != 0);

    logic [NREG-1:0][DW-1:0] regs_q, regs_d;
    logic [NREG-1:0]         busy_q, busy_d;
    logic [NREG-1:0]         wr_oh;
    logic [NREG-1:0]         set_oh;
    logic                    wr_live;

    // Write-back select: also clears the busy bit of the completing load.
    wr_decoder #(
        .AW   (AW),
        .NREG (NREG)
    ) u_wr_dec (
        .en_i     (we),
        .addr_i   (wa),
        .onehot_o (wr_oh)
    );

    // Load-issue select: marks the load destination busy.
    wr_decoder #(
        .AW   (AW),
        .NREG (NREG)
    ) u_set_dec (
        .en_i     (ld_issue),
        .addr_i   (ld_dst),
        .onehot_o (set_oh)
    );

    // Next-state: steer wd into the selected register; set beats clear on the same register.
    always_comb begin
        regs_d = regs_q;
        busy_d = (busy_q & ~wr_oh) | set_oh;
        for (int i = 0; i < int'(NREG); i++) begin
            if (wr_oh[i]) begin
                regs_d[i] = wd;
            end
        end
    end

    // Storage and scoreboard, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // A write-back is forwardable only when it targets a real (non-zero) register.
    assign wr_live = we && (wa != AW'(REG_ZERO));

    // Read ports with optional forwarding; a forwarded write-back also hides the stale busy bit.
    always_comb begin
        rd1   = regs_q[ra1];
        rd2   = regs_q[ra2];
        busy1 = busy_q[ra1];
        busy2 = busy_q[ra2];
        if (BYP_EN && wr_live && (wa == ra1)) begin
            rd1   = wd;
            busy1 = 1'b0;
        end
        if (BYP_EN && wr_live && (wa == ra2)) begin
            rd2   = wd;
            busy2 = 1'b0;
        end
        if (ra1 == AW'(REG_ZERO)) begin
            rd1   = '0;
            busy1 = 1'b0;
        end
        if (ra2 == AW'(REG_ZERO)) begin
            rd2   = '0;
            busy2 = 1'b0;
        end
        if (rst) begin
            rd1   = '0;
            rd2   = '0;
            busy1 = 1'b0;
            busy2 = 1'b0;
        end
    end

    // Hazard stall request.
    assign stall = busy1 | busy2;

endmodule : reg_file_wb

// File: tb/tb_reg_file_wb.sv
// Directed bench for reg_file_wb: one forwarding and one non-forwarding instance share stimulus.
module tb_reg_file_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ra1, ra2, wa, ld_dst;
    logic        we, ld_issue;
    logic [31:0] wd;

    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic        busy1_b, busy2_b, stall_b;
    logic        busy1_n, busy2_n, stall_n;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_file_wb #(.DW(32), .NREG(32), .AW(5), .BYPASS(1)) u_byp (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
        .we(we), .wa(wa), .wd(wd), .ld_issue(ld_issue), .ld_dst(ld_dst),
        .busy1(busy1_b), .busy2(busy2_b), .stall(stall_b)
    );

    reg_file_wb #(.DW(32), .NREG(32), .AW(5), .BYPASS(0)) u_nob (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
        .we(we), .wa(wa), .wd(wd), .ld_issue(ld_issue), .ld_dst(ld_dst),
        .busy1(busy1_n), .busy2(busy2_n), .stall(stall_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ld_issue = 1'b0; ld_dst = '0;
        ra1 = 5'($urandom_range(1, 31));
        ra2 = 5'($urandom_range(1, 31));
        #1;
        chk("rst_rd1_b", rd1_b, 32'h0);
        chk("rst_rd2_b", rd2_b, 32'h0);
        chk("rst_stall_b", 32'(stall_b), 32'h0);
        chk("rst_rd1_n", rd1_n, 32'h0);
        chk("rst_stall_n", 32'(stall_n), 32'h0);
        tick();
        tick();
        rst = 1'b0;

        // All registers read back zero after reset.
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(31 - i);
            #1;
            chk("rd_all_rd1", rd1_b, 32'h0);
            chk("rd_all_rd2", rd2_n, 32'h0);
        end

        // Plain write then read; neighbours untouched.
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
        tick();
        we = 1'b0;
        ra1 = 5'd5; ra2 = 5'd4;
        #1;
        chk("wr5_rd1_b", rd1_b, 32'hDEADBEEF);
        chk("wr5_rd1_n", rd1_n, 32'hDEADBEEF);
        chk("wr5_reg4", rd2_b, 32'h0);
        ra2 = 5'd6;
        #1;
        chk("wr5_reg6", rd2_n, 32'h0);

        // Register 0 discards writes and load issues.
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ld_issue = 1'b1; ld_dst = 5'd0;
        ra1 = 5'd1; ra2 = 5'd0;
        #1;
        chk("z_fwd_rd2_b", rd2_b, 32'h0);
        tick();
        we = 1'b0; ld_issue = 1'b0;
        #1;
        chk("z_rd2_b", rd2_b, 32'h0);
        chk("z_rd2_n", rd2_n, 32'h0);
        chk("z_busy2_b", 32'(busy2_b), 32'h0);
        chk("z_busy2_n", 32'(busy2_n), 32'h0);

        // Forwarding versus non-forwarding on a same-cycle write.
        we = 1'b1; wa = 5'd7; wd = 32'd1;
        tick();
        we = 1'b1; wa = 5'd7; wd = 32'd9; ra1 = 5'd7;
        #1;
        chk("byp_pre_b", rd1_b, 32'd9);
        chk("byp_pre_n", rd1_n, 32'd1);
        tick();
        we = 1'b0;
        #1;
        chk("byp_post_b", rd1_b, 32'd9);
        chk("byp_post_n", rd1_n, 32'd9);

        // Scoreboard set, clear, same-edge set-wins, independent registers.
        ra2 = 5'd0;
        ld_issue = 1'b1; ld_dst = 5'd3;
        tick();
        ld_issue = 1'b0; ra1 = 5'd3;
        #1;
        chk("sb_busy1_b", 32'(busy1_b), 32'h1);
        chk("sb_stall_b", 32'(stall_b), 32'h1);
        chk("sb_busy1_n", 32'(busy1_n), 32'h1);
        chk("sb_stall_n", 32'(stall_n), 32'h1);
        we = 1'b1; wa = 5'd3; wd = 32'h33;
        #1;
        chk("sb_mask_b", 32'(busy1_b), 32'h0);
        chk("sb_nomask_n", 32'(busy1_n), 32'h1);
        tick();
        we = 1'b0;
        #1;
        chk("sb_clr_b", 32'(busy1_b), 32'h0);
        chk("sb_clr_n", 32'(busy1_n), 32'h0);
        chk("sb_clr_rd1", rd1_n, 32'h33);
        ld_issue = 1'b1; ld_dst = 5'd3; we = 1'b1; wa = 5'd3; wd = 32'h44;
        tick();
        ld_issue = 1'b0; we = 1'b0;
        #1;
        chk("sb_setwin_b", 32'(busy1_b), 32'h1);
        chk("sb_setwin_n", 32'(busy1_n), 32'h1);
        chk("sb_setwin_rd1", rd1_b, 32'h44);
        ld_issue = 1'b1; ld_dst = 5'd8; we = 1'b1; wa = 5'd3; wd = 32'h45;
        tick();
        ld_issue = 1'b0; we = 1'b0; ra1 = 5'd3; ra2 = 5'd8;
        #1;
        chk("sb_ind_busy1", 32'(busy1_n), 32'h0);
        chk("sb_ind_busy2", 32'(busy2_b), 32'h1);
        chk("sb_ind_rd1", rd1_b, 32'h45);
        chk("sb_ind_stall", 32'(stall_n), 32'h1);

        // Asynchronous reset between edges.
        we = 1'b1; wa = 5'd10; wd = 32'h55;
        tick();
        we = 1'b0; ld_issue = 1'b1; ld_dst = 5'd10;
        tick();
        ld_issue = 1'b0; ra1 = 5'd10;
        #1;
        chk("ar_pre_rd1", rd1_b, 32'h55);
        chk("ar_pre_busy1", 32'(busy1_n), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_rd1_b", rd1_b, 32'h0);
        chk("ar_busy1_b", 32'(busy1_b), 32'h0);
        chk("ar_busy2_n", 32'(busy2_n), 32'h0);
        chk("ar_stall_n", 32'(stall_n), 32'h0);
        #1;
        rst = 1'b0;
        #1;
        chk("ar_held_rd1", rd1_n, 32'h0);
        chk("ar_held_busy1", 32'(busy1_b), 32'h0);
        ra2 = 5'd3;
        tick();
        chk("ar_edge_rd2", rd2_b, 32'h0);
        chk("ar_edge_busy2", 32'(busy2_n), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_reg_file_wb
